// File: rtl/bcd_serial_adder_n_if.sv
// Handshake and operand/result bundle for the serial BCD adder.
// The master launches operations; the slave (the adder) reports status and results.
interface bcd_serial_adder_n_if #(
    parameter int NDIGITS = 4
);
    logic                   start;
    logic                   sub;
    logic                   cin;
    logic [4*NDIGITS-1:0]   a;
    logic [4*NDIGITS-1:0]   b;
    logic                   busy;
    logic                   done;
    logic [4*NDIGITS-1:0]   sum;
    logic                   cout;
    logic                   err;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, err
    );
endinterface

// File: rtl/bcd_serial_adder_n.sv
// Packed-BCD adder/subtractor, one decimal digit per clock, LS digit first.
// Subtraction uses the 9's complement of b with a carry seed of 1 (10's complement).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands, mode and carry seed captured on start
// RUN   | one digit per cycle, idx 0..NDIGITS-1, carry held in c_q
// DONE  | one cycle; results and done pulse registered on the way out
module bcd_serial_adder_n #(
    parameter int NDIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_serial_adder_n_if.slave  bus
);

    localparam int W  = 4 * NDIGITS;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  sum_q;
    logic [IW-1:0] idx_q;
    logic          sub_q;
    logic          c_q;
    logic          bad_q;
    logic          err_q;
    logic          cout_q;
    logic          done_q;

    logic          err_cap;
    logic [3:0]    a_dig;
    logic [3:0]    b_dig;
    logic [3:0]    bd;
    logic [4:0]    t;
    logic [3:0]    s_dig;
    logic          c_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (idx_q == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        err_cap = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            err_cap = err_cap | (bus.a[4*i +: 4] > 4'd9) | (bus.b[4*i +: 4] > 4'd9);
        end
    end

    // Decimal correction: a 5-bit sum above 9 wraps by adding 6 and carries.
    always_comb begin
        a_dig = a_q[4*idx_q +: 4];
        b_dig = b_q[4*idx_q +: 4];
        bd    = sub_q ? (4'd9 - b_dig) : b_dig;
        t     = {1'b0, a_dig} + {1'b0, bd} + {4'b0000, c_q};
        if (t > 5'd9) begin
            s_dig  = 4'(t + 5'd6);
            c_next = 1'b1;
        end else begin
            s_dig  = t[3:0];
            c_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            sum_q  <= '0;
            idx_q  <= '0;
            sub_q  <= 1'b0;
            c_q    <= 1'b0;
            bad_q  <= 1'b0;
            err_q  <= 1'b0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        sub_q <= bus.sub;
                        c_q   <= bus.sub ? 1'b1 : bus.cin;
                        bad_q <= err_cap;
                        idx_q <= '0;
                    end
                end
                RUN: begin
                    acc_q[4*idx_q +: 4] <= s_dig;
                    c_q                 <= c_next;
                    idx_q               <= idx_q + 1'b1;
                end
                DONE: begin
                    sum_q  <= bad_q ? '0 : acc_q;
                    cout_q <= bad_q ? 1'b0 : c_q;
                    err_q  <= bad_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_n.sv
// Scoreboard bench for the serial BCD adder: expected results come from an
// integer decimal model and are checked, with done latency, on each done pulse.
module tb_bcd_serial_adder_n;

    localparam int ND = 4;
    localparam int W  = 4 * ND;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           edge_no;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_serial_adder_n_if #(.NDIGITS(ND)) bus ();

    bcd_serial_adder_n #(.NDIGITS(ND)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t         sb[$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_push = 0;
    int           n_done = 0;
    logic [W-1:0] held_sum = '0;
    logic         held_cout = 1'b0;
    logic         held_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic s, input logic c,
                                   input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t   e;
        longint x = 0;
        longint y = 0;
        longint p = 1;
        longint tot;
        logic   bad = 1'b0;
        logic [3:0] d;
        for (int i = ND - 1; i >= 0; i--) begin
            d = av[4*i +: 4];
            if (d > 4'd9) bad = 1'b1;
            x = x * 10 + longint'(d);
            d = bv[4*i +: 4];
            if (d > 4'd9) bad = 1'b1;
            y = y * 10 + longint'(d);
            p = p * 10;
        end
        e.sum = '0;
        e.edge_no = 0;
        if (bad) begin
            e.cout = 1'b0;
            e.err  = 1'b1;
            return e;
        end
        e.err = 1'b0;
        if (!s) begin
            tot    = x + y + longint'(c);
            e.cout = (tot >= p);
            tot    = tot % p;
        end else if (x >= y) begin
            tot    = x - y;
            e.cout = 1'b1;
        end else begin
            tot    = p - (y - x);
            e.cout = 1'b0;
        end
        for (int i = 0; i < ND; i++) begin
            e.sum[4*i +: 4] = 4'(tot % 10);
            tot = tot / 10;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'($urandom_range(9));
        return r;
    endfunction

    // Results must hold between done pulses; done pulses are checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_sum  <= '0;
            held_cout <= 1'b0;
            held_err  <= 1'b0;
        end else if (bus.done) begin
            n_done <= n_done + 1;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", bus.sum, e.sum);
                chk("cout", bus.cout, e.cout);
                chk("err", bus.err, e.err);
                chk("done_latency", cyc - e.edge_no, ND + 1);
            end
            held_sum  <= bus.sum;
            held_cout <= bus.cout;
            held_err  <= bus.err;
        end else begin
            chk("sum_hold", bus.sum, held_sum);
            chk("cout_hold", bus.cout, held_cout);
            chk("err_hold", bus.err, held_err);
        end
    end

    task automatic launch(input logic s, input logic c, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        @(negedge clk);
        bus.sub   = s;
        bus.cin   = c;
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        e = model(s, c, av, bv);
        e.edge_no = cyc;
        sb.push_back(e);
        n_push++;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic t1_run(input string tag);
        launch(1'b0, 1'b0, 16'h0456, 16'h0789);
        chk({tag, "_busy0"}, bus.busy, 1);
        for (int i = 1; i < ND; i++) begin
            @(negedge clk);
            chk({tag, "_busy"}, bus.busy, 1);
        end
        @(negedge clk);
        chk({tag, "_busy_end"}, bus.busy, 0);
        chk({tag, "_done_early"}, bus.done, 0);
        drain();
    endtask

    initial begin
        int k;
        exp_t e;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_err", bus.err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        t1_run("t1");

        launch(1'b0, 1'b0, 16'h9999, 16'h0001); drain();
        launch(1'b0, 1'b1, 16'h9999, 16'h9999); drain();

        launch(1'b1, 1'b0, 16'h0789, 16'h0456); drain();
        launch(1'b1, 1'b1, 16'h0456, 16'h0789); drain();
        launch(1'b1, 1'b0, 16'h1234, 16'h1234); drain();

        launch(1'b0, 1'b0, 16'h00A3, 16'h0001); drain();
        launch(1'b0, 1'b0, 16'h0001, 16'h0001); drain();
        launch(1'b1, 1'b0, 16'h0010, 16'h0F00); drain();

        for (int i = 0; i < 8; i++) begin
            launch(1'($urandom), 1'($urandom), rand_bcd(), rand_bcd());
            drain();
        end

        // Held start with changing operands: only first capture and the one at +6 edges count.
        @(negedge clk);
        bus.sub = 1'b0; bus.cin = 1'b1; bus.a = 16'h1234; bus.b = 16'h4321;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        e = model(1'b0, 1'b1, 16'h1234, 16'h4321);
        e.edge_no = cyc;
        k = cyc;
        sb.push_back(e);
        n_push++;
        for (int i = 0; i < ND + 1; i++) begin
            @(negedge clk);
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.sub = 1'($urandom);
            bus.cin = 1'($urandom);
        end
        @(negedge clk);
        bus.sub = 1'b1; bus.cin = 1'b0; bus.a = 16'h5000; bus.b = 16'h0001;
        @(posedge clk);
        #1;
        e = model(1'b1, 1'b0, 16'h5000, 16'h0001);
        e.edge_no = k + ND + 2;
        sb.push_back(e);
        n_push++;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (ND + 3) @(negedge clk);

        // Abort during RUN idx=2.
        launch(1'b0, 1'b0, 16'h0456, 16'h0789);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_sum", bus.sum, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_cout", bus.cout, 0);
        sb.delete();
        n_push--;
        for (int i = 0; i < ND + 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", bus.done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        t1_run("t6");

        repeat (ND + 3) @(negedge clk);
        chk("done_count", n_done, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
